seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Reverse path of the hex-to-seven-segment driver. It samples a time-multiplexed, active-low seven-segment display bus (digit anodes plus segment lines), debounces each digit dwell, and decodes every segment pattern back to a 4-bit hex value. It then assembles a full multi-digit word and flags undecodable patterns. It sits between the board display pins (or the internal display-driver outputs) and the self-check/debug logic of the CPU.

## Interface
- `DIGITS`, default 8: number of multiplexed digits; `value` width is 4*DIGITS.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a dwell is accepted; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `an_n` input DIGITS: digit select, active-low, exactly one bit low when a digit is driven.
- `seg_n` input 7: segments, active-low, bit0=a … bit6=g (0 = lit).
- `value` output 4*DIGITS: assembled word, digit i at bits [4i+3:4i].
- `blank_mask` output DIGITS: digit i showed all segments off (seg_n=7'h7F) in the last frame.
- `frame_done` output 1: one-cycle pulse when `value`/`blank_mask` update.
- `err` output 1: one-cycle pulse on an accepted dwell with an undecodable pattern.

## Operation
- Inputs pass through a 2-flop synchronizer. All further logic uses the synchronized pair (an, seg).
- Dwell tracker FSM:
  - **IDLE**: `an` is not one-hot-low (all high, or multiple low). Counter = 0.
  - **SETTLE**: one-hot-low; the counter increments each cycle the pair matches the previous cycle's pair. Any change restarts the count at 1.
  - **LOCKED**: entered when counter reaches STABLE_CYCLES; the dwell commits exactly once on that edge. The FSM stays in LOCKED until the pair changes, then goes to SETTLE (new one-hot) or IDLE.
- Commit decode uses the inverse of the team's hex patterns: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex of seg_n).
  - 7F → blank: nibble 0, blank bit set.
  - Any other pattern → `err` pulse. The shadow nibble is left unchanged and the digit is NOT marked seen.
- A shadow register and a `seen` mask are updated on valid commits. When `seen` becomes all-ones, shadow → `value`, blank shadow → `blank_mask`, `frame_done` pulses, and `seen` clears.
- A re-commit of an already-seen digit before the frame completes overwrites its shadow nibble and does not complete the frame.

## Timing
- Reset: `value`=0, `blank_mask`=0, `frame_done`=0, `err`=0, FSM IDLE, `seen`=0, shadow=0. Reset asserted mid-frame discards the partial frame.
- Latency: a pair stable at the pins from edge k commits on edge k+1+STABLE_CYCLES. `frame_done` and `err` are registered and high during the following cycle.
- A dwell shorter than STABLE_CYCLES synchronized cycles is ignored.
- Counter saturates at STABLE_CYCLES; no wrap during long dwells.
- A final commit that is both the completing digit and a blank still completes the frame.
- `err` and `frame_done` never assert in the same cycle, because an invalid commit cannot complete a frame.

## Configuration
- `SEG_SCAN_DP_EN` defined: adds input `dp_n` (1 bit, active-low, synchronized and compared with the pair) and output `dp_mask` [DIGITS-1:0], latched with `value` on `frame_done`, reset 0.
- Undefined: no `dp_n`/`dp_mask` ports; stability depends on `an_n`/`seg_n` only.

## Structure
- Package `seg_pkg`:
  - `SEG_0`..`SEG_F` pattern constants and `SEG_BLANK`=7'h7F.
  - FSM state typedef {IDLE, SETTLE, LOCKED}.
- Sub-module `seg_pattern_decode`: combinational seg_n → {valid, blank, nibble}, sharing the pkg constants.
- Top: synchronizer, dwell FSM/counter, one-hot check, shadow/seen registers.

## Test plan
- Scan digits 0..7 showing 1,2,3,4,5,6,7,8 with 10-cycle dwells → `frame_done` once, `value`=32'h87654321, `blank_mask`=0.
- Digit 3 dwell of STABLE_CYCLES-1 cycles, then a proper scan → digit 3 is taken only from the proper dwell, and no early `frame_done`.
- Digit 2 shows seg_n=7'h55 → `err` pulse; after a full scan with digit 2 invalid, no `frame_done`. A corrected scan later gives `frame_done`.
- Digit 5 shows 7'h7F in an otherwise full scan → `blank_mask`=8'h20 and nibble 5 = 0.
- `an_n`=8'hFC (two low) held 20 cycles → no commit, FSM IDLE, outputs unchanged.
- Assert `rst_n` after 4 committed digits, release, then full scan of F's → `value`=32'hFFFFFFFF with exactly one `frame_done`.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan decoder.
//   - SEG_0..SEG_F : active-low segment patterns (seg_n, bit0=a .. bit6=g)
//   - SEG_BLANK    : all segments off
//   - dwell_state_e: dwell tracker FSM states
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } dwell_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational inverse of the hex-to-seven-segment map.
// Ports:
//   seg_n_i  [6:0] active-low segment pattern
//   valid_o        pattern is a hex digit or blank
//   blank_o        pattern is all segments off (nibble reported as 0)
//   nibble_o [3:0] decoded hex value
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic       valid_o,
    output logic       blank_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b1;
        blank_o  = 1'b0;
        nibble_o = 4'h0;
        case (seg_n_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: blank_o  = 1'b1;
            default:   valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed active-low seven-segment bus, accepts each
// digit dwell once it has been stable for STABLE_CYCLES synchronized cycles, decodes
// the pattern and assembles a DIGITS-wide hex word.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   an_n  [DIGITS-1:0]  digit select, active-low, one-hot when a digit is driven
//   seg_n [6:0]         segments, active-low
//   value [4*DIGITS-1:0] assembled word, digit i at [4i+3:4i]
//   blank_mask          digits that were blank in the last frame
//   frame_done          one-cycle pulse when value/blank_mask update
//   err                 one-cycle pulse on an accepted undecodable dwell
// Optional feature macro SEG_SCAN_DP_EN adds dp_n input and dp_mask output
// (decimal points, 1 = lit), latched together with value.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  frame_done,
    output logic                  err
`ifdef SEG_SCAN_DP_EN
    ,
    input  logic                  dp_n,
    output logic [DIGITS-1:0]     dp_mask
`endif
);

`ifdef SEG_SCAN_DP_EN
    localparam int unsigned PW = DIGITS + 8;
`else
    localparam int unsigned PW = DIGITS + 7;
`endif
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    // Synchronizer and previous-cycle copy of the {dp, an, seg} pair.
    logic [PW-1:0] pair_raw;
    logic [PW-1:0] s1_q, s2_q, prev_q;

`ifdef SEG_SCAN_DP_EN
    assign pair_raw = {dp_n, an_n, seg_n};
`else
    assign pair_raw = {an_n, seg_n};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '1;
            s2_q   <= '1;
            prev_q <= '1;
        end else begin
            s1_q   <= pair_raw;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    logic [DIGITS-1:0] sel;
    logic [6:0]        seg;
    logic              onehot;
    logic              changed;

    assign sel     = ~s2_q[DIGITS+6:7];
    assign seg     = s2_q[6:0];
    assign onehot  = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    assign changed = (s2_q != prev_q);

    // Dwell tracker.
    dwell_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!onehot) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            if (changed || state_q == IDLE) begin
                cnt_d = 8'd1;
            end else if (cnt_q < STABLE) begin
                cnt_d = cnt_q + 8'd1;
            end
            // A saturated LOCKED dwell must not commit again.
            commit = (cnt_d == STABLE) && (changed || state_q != LOCKED);
            if (commit || (state_q == LOCKED && !changed)) begin
                state_d = LOCKED;
            end else begin
                state_d = SETTLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic       dec_valid;
    logic       dec_blank;
    logic [3:0] dec_nibble;

    seg_pattern_decode u_decode (
        .seg_n_i  (seg),
        .valid_o  (dec_valid),
        .blank_o  (dec_blank),
        .nibble_o (dec_nibble)
    );

    // Frame assembly.
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_mask_q, blank_mask_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;
`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]   dp_mask_q, dp_mask_d;
`endif

    always_comb begin
        shadow_d     = shadow_q;
        blank_sh_d   = blank_sh_q;
        seen_d       = seen_q;
        value_d      = value_q;
        blank_mask_d = blank_mask_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
`ifdef SEG_SCAN_DP_EN
        dp_sh_d      = dp_sh_q;
        dp_mask_d    = dp_mask_q;
`endif
        if (commit) begin
            if (!dec_valid) begin
                // Undecodable: shadow untouched, digit stays unseen.
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (sel[i]) begin
                        shadow_d[4*i +: 4] = dec_nibble;
                        blank_sh_d[i]      = dec_blank;
                        seen_d[i]          = 1'b1;
`ifdef SEG_SCAN_DP_EN
                        dp_sh_d[i]         = ~s2_q[DIGITS+7];
`endif
                    end
                end
                if (&seen_d) begin
                    value_d      = shadow_d;
                    blank_mask_d = blank_sh_d;
                    frame_done_d = 1'b1;
                    seen_d       = '0;
`ifdef SEG_SCAN_DP_EN
                    dp_mask_d    = dp_sh_d;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            blank_sh_q   <= '0;
            seen_q       <= '0;
            value_q      <= '0;
            blank_mask_q <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_sh_q      <= '0;
            dp_mask_q    <= '0;
`endif
        end else begin
            shadow_q     <= shadow_d;
            blank_sh_q   <= blank_sh_d;
            seen_q       <= seen_d;
            value_q      <= value_d;
            blank_mask_q <= blank_mask_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef SEG_SCAN_DP_EN
            dp_sh_q      <= dp_sh_d;
            dp_mask_q    <= dp_mask_d;
`endif
        end
    end

    assign value      = value_q;
    assign blank_mask = blank_mask_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
`ifdef SEG_SCAN_DP_EN
    assign dp_mask    = dp_mask_q;
`endif

endmodule
